// File: rtl/wr_lead_pkt_pkg.sv
// rtl/wr_lead_pkt_pkg.sv - shared types and helpers for the wr_lead_pkt ingress front end
// Contents: receive FSM state encoding, drop counter width/limit, saturating increment.
package wr_lead_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wr_lead_pkt_fifo.sv
// rtl/wr_lead_pkt_fifo.sv - payload RAM FIFO with speculative write pointer and commit/rollback
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      speculative write at wr_spec
//   commit              publish wr_spec (plus a same-cycle write) to the reader
//   rollback            reload wr_spec from the committed pointer; wins over wr_en
//   rd_en, rd_data      registered read of committed data, ignored while empty
//   empty               no committed beats left to read
//   full                speculative occupancy equals DEPTH
//   used                speculative occupancy (wr_spec - rd_ptr)
module wr_lead_pkt_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              rollback,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [$clog2(DEPTH):0] used
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_spec;
    logic [PW-1:0]     wr_commit;
    logic [PW-1:0]     rd_ptr;
    logic              wr_go;
    logic              rd_go;

    // A rollback in the same cycle as a write discards that write too.
    assign wr_go = wr_en && !rollback;
    assign rd_go = rd_en && !empty;

    // Pointers carry an extra MSB so full and empty are distinguishable after wrap.
    assign empty = (wr_commit == rd_ptr);
    assign used  = wr_spec - rd_ptr;
    assign full  = (used == DEPTH_L);

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[wr_spec[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_spec   <= '0;
            wr_commit <= '0;
        end else if (rollback) begin
            wr_spec <= wr_commit;
        end else begin
            if (wr_go) begin
                wr_spec <= wr_spec + PW'(1);
            end
            // The eop beat is written and committed in the same cycle.
            if (commit) begin
                wr_commit <= wr_spec + PW'(wr_go);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            rd_data <= '0;
        end else if (rd_go) begin
            rd_ptr  <= rd_ptr + PW'(1);
            rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/wr_lead_pkt.sv
// rtl/wr_lead_pkt.sv - ingress packet front end: header parse, payload buffering, atomic drop
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   wr_sop/wr_eop/wr_vld/wr_data input beats (header beat carries {pri, dest_port})
//   full                        upstream must not start a packet while high
//   info_data/info_vld/info_rdy show-ahead {len, pri, dest_port} per intact packet
//   data_ren/data_out/data_empty registered payload read port (committed beats only)
//   drop_cnt                    saturating count of dropped packets
module wr_lead_pkt
    import wr_lead_pkt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRI_W      = 3,
    parameter int PORT_W     = 4,
    parameter int LEN_W      = 12,
    parameter int MAX_LEN    = 1024,
    parameter int FIFO_DEPTH = 4096,
    parameter int INFO_DEPTH = 16
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic                            wr_sop,
    input  logic                            wr_eop,
    input  logic                            wr_vld,
    input  logic [DATA_W-1:0]               wr_data,
    output logic                            full,
    output logic [LEN_W+PRI_W+PORT_W-1:0]   info_data,
    output logic                            info_vld,
    input  logic                            info_rdy,
    input  logic                            data_ren,
    output logic [DATA_W-1:0]               data_out,
    output logic                            data_empty,
    output logic [DROP_CNT_W-1:0]           drop_cnt
);

    localparam int INFO_W = LEN_W + PRI_W + PORT_W;
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam int FPW    = FAW + 1;
    localparam int IAW    = $clog2(INFO_DEPTH);
    localparam int IPW    = IAW + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L    = LEN_W'(MAX_LEN);
    // FIFO_DEPTH - used < MAX_LEN+1  <=>  used >= FIFO_DEPTH - MAX_LEN
    localparam logic [FPW-1:0]   FULL_THR     = FPW'(FIFO_DEPTH - MAX_LEN);
    localparam logic [IPW-1:0]   INFO_DEPTH_L = IPW'(INFO_DEPTH);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [PRI_W-1:0]   pri_q;
    logic [PORT_W-1:0]  port_q;
    logic               hdr_cap;
    logic               fifo_wr, fifo_commit, fifo_rollback;
    logic               fifo_full;
    logic [FPW-1:0]     fifo_used;
    logic               info_push;
    logic               drop_evt;

    logic [INFO_W-1:0]  info_mem [INFO_DEPTH];
    logic [IPW-1:0]     info_wp, info_rp;
    logic [IPW-1:0]     info_cnt;
    logic               info_full;
    logic               info_pop;

    wr_lead_pkt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_pkt_fifo (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .wr_en    (fifo_wr),
        .wr_data  (wr_data),
        .commit   (fifo_commit),
        .rollback (fifo_rollback),
        .rd_en    (data_ren),
        .rd_data  (data_out),
        .empty    (data_empty),
        .full     (fifo_full),
        .used     (fifo_used)
    );

    assign info_cnt  = info_wp - info_rp;
    assign info_full = (info_cnt == INFO_DEPTH_L);
    assign info_vld  = (info_wp != info_rp);
    assign info_pop  = info_vld && info_rdy;
    assign info_data = info_vld ? info_mem[info_rp[IAW-1:0]] : '0;
    assign full      = (fifo_used >= FULL_THR) || info_full;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        hdr_cap       = 1'b0;
        fifo_wr       = 1'b0;
        fifo_commit   = 1'b0;
        fifo_rollback = 1'b0;
        info_push     = 1'b0;
        drop_evt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_vld && wr_sop) begin
                    if (wr_eop) begin
                        drop_evt = 1'b1;
                    end else begin
                        hdr_cap       = 1'b1;
                        len_d         = '0;
                        fifo_rollback = 1'b1;
                        state_d       = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (wr_vld && wr_sop) begin
                    // Truncated packet: discard it and start over on the new header.
                    fifo_rollback = 1'b1;
                    drop_evt      = 1'b1;
                    hdr_cap       = 1'b1;
                    len_d         = '0;
                    state_d       = wr_eop ? ST_IDLE : ST_RECV;
                end else if (wr_vld) begin
                    if (fifo_full || (len_q == MAX_LEN_L)) begin
                        fifo_rollback = 1'b1;
                        drop_evt      = 1'b1;
                        state_d       = wr_eop ? ST_IDLE : ST_DROP;
                    end else if (wr_eop) begin
                        // Info FIFO fullness is judged on the registered count only.
                        if (info_full) begin
                            fifo_rollback = 1'b1;
                            drop_evt      = 1'b1;
                        end else begin
                            fifo_wr     = 1'b1;
                            fifo_commit = 1'b1;
                            info_push   = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        fifo_wr = 1'b1;
                        len_d   = len_q + LEN_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (wr_vld && wr_sop) begin
                    if (wr_eop) begin
                        drop_evt = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        hdr_cap       = 1'b1;
                        len_d         = '0;
                        fifo_rollback = 1'b1;
                        state_d       = ST_RECV;
                    end
                end else if (wr_vld && wr_eop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            pri_q    <= '0;
            port_q   <= '0;
            drop_cnt <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            if (hdr_cap) begin
                pri_q  <= wr_data[PRI_W+PORT_W-1:PORT_W];
                port_q <= wr_data[PORT_W-1:0];
            end
            if (drop_evt) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    // len_q excludes the eop beat, which is counted here as it is pushed.
    always_ff @(posedge sys_clk) begin
        if (info_push) begin
            info_mem[info_wp[IAW-1:0]] <= {len_q + LEN_W'(1), pri_q, port_q};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            info_wp <= '0;
            info_rp <= '0;
        end else begin
            if (info_push) begin
                info_wp <= info_wp + IPW'(1);
            end
            if (info_pop) begin
                info_rp <= info_rp + IPW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wr_lead_pkt.sv
// tb/tb_wr_lead_pkt.sv - directed self-checking bench for wr_lead_pkt
module tb_wr_lead_pkt;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        wr_sop, wr_eop, wr_vld;
    logic [7:0]  wr_data;
    logic        full;
    logic [18:0] info_data;
    logic        info_vld;
    logic        info_rdy;
    logic        data_ren;
    logic [7:0]  data_out;
    logic        data_empty;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    wr_lead_pkt dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .wr_sop     (wr_sop),
        .wr_eop     (wr_eop),
        .wr_vld     (wr_vld),
        .wr_data    (wr_data),
        .full       (full),
        .info_data  (info_data),
        .info_vld   (info_vld),
        .info_rdy   (info_rdy),
        .data_ren   (data_ren),
        .data_out   (data_out),
        .data_empty (data_empty),
        .drop_cnt   (drop_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic sop, input logic eop, input logic [7:0] d);
        wr_vld  = 1'b1;
        wr_sop  = sop;
        wr_eop  = eop;
        wr_data = d;
        @(posedge sys_clk);
        #1;
        wr_vld = 1'b0;
        wr_sop = 1'b0;
        wr_eop = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] exp);
        data_ren = 1'b1;
        @(posedge sys_clk);
        #1;
        data_ren = 1'b0;
        chk(tag, 32'(data_out), 32'(exp));
    endtask

    task automatic pop_chk(input string tag, input logic [18:0] exp);
        chk({tag, "_vld"}, 32'(info_vld), 32'd1);
        chk(tag, 32'(info_data), 32'(exp));
        info_rdy = 1'b1;
        @(posedge sys_clk);
        #1;
        info_rdy = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_info_vld"}, 32'(info_vld), 32'd0);
        chk({tag, "_info_data"}, 32'(info_data), 32'd0);
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_data_empty"}, 32'(data_empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        wr_sop = 1'b0; wr_eop = 1'b0; wr_vld = 1'b0; wr_data = '0;
        info_rdy = 1'b0; data_ren = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_reset_vals("rst");
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // Normal packet: header 0x25 -> pri 2, port 5; payload 0x10..0x14
        send(1'b1, 1'b0, 8'h25);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 8'(8'h10 + i));
        chk("norm_pre_info_vld", 32'(info_vld), 32'd0);
        chk("norm_pre_empty", 32'(data_empty), 32'd1);
        send(1'b0, 1'b1, 8'h14);
        chk("norm_post_empty", 32'(data_empty), 32'd0);
        for (int i = 0; i < 5; i++) rd_chk($sformatf("norm_rd%0d", i), 8'(8'h10 + i));
        chk("norm_drained", 32'(data_empty), 32'd1);
        rd_chk("norm_rd_empty_hold", 8'h14);
        pop_chk("norm_info", {12'd5, 3'd2, 4'd5});
        chk("norm_info_gone", 32'(info_vld), 32'd0);

        // Back-to-back packets of length 1 and 3
        send(1'b1, 1'b0, 8'h13);
        send(1'b0, 1'b1, 8'hA0);
        send(1'b1, 1'b0, 8'h7F);
        send(1'b0, 1'b0, 8'hA1);
        send(1'b0, 1'b0, 8'hA2);
        send(1'b0, 1'b1, 8'hA3);
        pop_chk("b2b_info0", {12'd1, 3'd1, 4'd3});
        pop_chk("b2b_info1", {12'd3, 3'd7, 4'hF});
        chk("b2b_info_gone", 32'(info_vld), 32'd0);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("b2b_rd%0d", i), 8'(8'hA0 + i));
        chk("b2b_empty", 32'(data_empty), 32'd1);
        chk("b2b_drop", 32'(drop_cnt), 32'd0);

        // Malformed: second sop after 3 payload beats
        send(1'b1, 1'b0, 8'h25);
        send(1'b0, 1'b0, 8'hB0);
        send(1'b0, 1'b0, 8'hB1);
        send(1'b0, 1'b0, 8'hB2);
        send(1'b1, 1'b0, 8'h46);
        send(1'b0, 1'b0, 8'hC0);
        send(1'b0, 1'b1, 8'hC1);
        chk("mal_drop", 32'(drop_cnt), 32'd1);
        pop_chk("mal_info", {12'd2, 3'd4, 4'd6});
        chk("mal_info_gone", 32'(info_vld), 32'd0);
        rd_chk("mal_rd0", 8'hC0);
        rd_chk("mal_rd1", 8'hC1);
        chk("mal_empty", 32'(data_empty), 32'd1);

        // Oversize: 1029 payload beats, rollback on beat 1025
        send(1'b1, 1'b0, 8'h31);
        for (int i = 1; i <= 1029; i++) begin
            send(1'b0, (i == 1029), 8'(i));
            if (i == 1024) chk("ovr_mid_empty", 32'(data_empty), 32'd1);
            if (i == 1025) chk("ovr_drop_at_1025", 32'(drop_cnt), 32'd2);
        end
        chk("ovr_drop", 32'(drop_cnt), 32'd2);
        chk("ovr_info", 32'(info_vld), 32'd0);
        chk("ovr_empty", 32'(data_empty), 32'd1);

        // Header-only packet is malformed; stray payload beat is ignored
        send(1'b1, 1'b1, 8'h12);
        chk("hdr_only_drop", 32'(drop_cnt), 32'd3);
        send(1'b0, 1'b0, 8'h99);
        chk("stray_drop", 32'(drop_cnt), 32'd3);
        chk("stray_empty", 32'(data_empty), 32'd1);
        send(1'b1, 1'b0, 8'h5A);
        send(1'b0, 1'b1, 8'hE7);
        pop_chk("recover_info", {12'd1, 3'd5, 4'hA});
        rd_chk("recover_rd", 8'hE7);

        // Backpressure: 16 packets with info_rdy low
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("bp_full_before_16", 32'(full), 32'd0);
            send(1'b1, 1'b0, {1'b0, 3'(i), 4'(i)});
            send(1'b0, 1'b1, 8'(8'hD0 + i));
        end
        chk("bp_full", 32'(full), 32'd1);
        send(1'b1, 1'b0, 8'h77);
        send(1'b0, 1'b1, 8'hEE);
        chk("bp_17_drop", 32'(drop_cnt), 32'd4);
        for (int i = 0; i < 16; i++) begin
            pop_chk($sformatf("bp_info%0d", i), {12'd1, 3'(i), 4'(i)});
            if (i == 0) chk("bp_full_released", 32'(full), 32'd0);
        end
        chk("bp_info_gone", 32'(info_vld), 32'd0);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("bp_rd%0d", i), 8'(8'hD0 + i));
        chk("bp_empty", 32'(data_empty), 32'd1);

        // Reset during packet 2 with packet 1 committed
        send(1'b1, 1'b0, 8'h11);
        send(1'b0, 1'b0, 8'hE0);
        send(1'b0, 1'b1, 8'hE1);
        send(1'b1, 1'b0, 8'h22);
        send(1'b0, 1'b0, 8'hF0);
        chk("mid_pre_info", 32'(info_vld), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        send(1'b0, 1'b0, 8'hF1);
        send(1'b0, 1'b1, 8'hF2);
        chk("post_rst_info", 32'(info_vld), 32'd0);
        chk("post_rst_empty", 32'(data_empty), 32'd1);
        chk("post_rst_drop", 32'(drop_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
